// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / load-store) byte-serial RAM arbiter.
// Reads stream one address per cycle and assemble a little-endian word;
// stores write one byte per cycle, pacing UART-space writes on io_buffer_full.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [31:0]           if_data,
  input  logic                  ls_valid,
  input  logic                  ls_wr,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [1:0]            ls_size,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_ready,
  output logic [31:0]           ls_rdata,
  input  logic                  if_flush
);
  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q, buf_q, rd_word;
  logic [2:0]            len_q, idx_q, len_req;
  logic                  restart_q, last_if_q, if_ready_q, ls_ready_q;
  logic                  reading, can_grant, pick_ls, grant_ls, grant_if;
  logic                  io_hold, rd_done, st_fire, st_done;
  logic [5:0]            rd_shift;

  // idx_q counts cycles of the transaction: address idx_q is on the bus,
  // and mem_din holds byte idx_q-1 (RAM has one cycle of read latency).
  assign reading   = (state_q == IFETCH) || (state_q == LOAD);
  assign can_grant = (state_q == IDLE) && !if_ready_q && !ls_ready_q && !if_flush;
  assign pick_ls   = ls_valid && (!if_valid || last_if_q);
  assign grant_ls  = can_grant && pick_ls;
  assign grant_if  = can_grant && if_valid && !pick_ls;
  assign len_req   = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
  assign io_hold   = (base_q[17:16] == 2'b11) && io_buffer_full;
  assign rd_done   = reading && !restart_q && (idx_q == len_q);
  assign st_fire   = (state_q == STORE) && !io_hold;
  assign st_done   = st_fire && (idx_q == len_q - 3'd1);

  // Bytes shift in from the top; the final shift right zero-extends short loads.
  assign rd_shift  = 6'd32 - {len_q, 3'b000};
  assign rd_word   = {mem_din, buf_q[31:8]} >> rd_shift;

  // A ready pulse held across a pause is only presented once the block runs.
  assign if_ready  = if_ready_q && rdy_in;
  assign ls_ready  = ls_ready_q && rdy_in;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: grant from IDLE, finish or abort reads, finish stores.
  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (grant_ls)      state_d = ls_wr ? STORE : LOAD;
          else if (grant_if) state_d = IFETCH;
        end
        IFETCH, LOAD: if (if_flush || rd_done) state_d = IDLE;
        STORE:        if (st_done) state_d = IDLE;
        default:      state_d = IDLE;
      endcase
    end
  end

  // Datapath: request capture, byte counter, read assembly, ready pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      base_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      restart_q  <= 1'b0;
      last_if_q  <= 1'b1;
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      if_data    <= '0;
      ls_rdata   <= '0;
    end else if (!rdy_in) begin
      // A paused read loses its in-flight RAM byte; rerun it from byte 0.
      if (reading) restart_q <= 1'b1;
    end else begin
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          idx_q     <= '0;
          buf_q     <= '0;
          restart_q <= 1'b0;
          if (grant_ls) begin
            base_q    <= ls_addr;
            wdata_q   <= ls_wdata;
            len_q     <= len_req;
            last_if_q <= 1'b0;
          end else if (grant_if) begin
            base_q    <= if_addr;
            len_q     <= 3'd4;
            last_if_q <= 1'b1;
          end
        end
        IFETCH, LOAD: begin
          if (restart_q) begin
            // Resume cycle stands in for the original grant cycle.
            restart_q <= 1'b0;
            idx_q     <= '0;
            buf_q     <= '0;
          end else if (!if_flush) begin
            if (idx_q != 3'd0) buf_q <= {mem_din, buf_q[31:8]};
            if (rd_done) begin
              if (state_q == IFETCH) begin
                if_ready_q <= 1'b1;
                if_data    <= rd_word;
              end else begin
                ls_ready_q <= 1'b1;
                ls_rdata   <= rd_word;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        STORE: begin
          if (st_fire) idx_q <= idx_q + 3'd1;
          if (st_done) ls_ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RAM bus: idle bus is all zero; writes are suppressed while paused or held.
  always_comb begin
    mem_wr   = 1'b0;
    mem_a    = '0;
    mem_dout = '0;
    case (state_q)
      STORE: begin
        mem_a    = base_q + ADDR_WIDTH'(idx_q);
        mem_dout = wdata_q[{idx_q[1:0], 3'b000} +: 8];
        mem_wr   = rdy_in && !io_hold;
      end
      IFETCH, LOAD: begin
        if (!restart_q && (idx_q < len_q)) mem_a = base_q + ADDR_WIDTH'(idx_q);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions against a
// transaction-level model (byte memory + latency rules).
module tb_mem_arbiter;
  localparam int AW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in;
  logic [7:0]    mem_din = 8'h00;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr, io_buffer_full;
  logic          if_valid, if_ready;
  logic [AW-1:0] if_addr, ls_addr;
  logic [31:0]   if_data, ls_wdata, ls_rdata;
  logic          ls_valid, ls_wr, ls_ready, if_flush;
  logic [1:0]    ls_size;

  int checks = 0;
  int errors = 0;

  bit [7:0] ram [bit [31:0]];   // what the DUT actually wrote
  bit [7:0] mdl [bit [31:0]];   // what the transactions should have produced

  mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .if_flush(if_flush)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction
  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : dflt(a);
  endfunction

  // Synchronous RAM: one cycle read latency, writes on mem_wr.
  always @(posedge clk_in) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      ram[a + 32'(k)] = w[8*k +: 8];
      mdl[a + 32'(k)] = w[8*k +: 8];
    end
  endtask

  // One request on one port; checks bus sequence, ready latency and data.
  task automatic do_txn(input bit is_if, input bit wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wd);
    int n, lat;
    logic [31:0] exp;
    bit seen;
    logic r;
    n    = is_if ? 4 : (size == 2'd0 ? 1 : (size == 2'd1 ? 2 : 4));
    lat  = wr ? n + 1 : n + 2;
    exp  = '0;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (wr) mdl[addr + 32'(k)] = wd[8*k +: 8];
      else    exp = exp | (32'(mdl_rd(addr + 32'(k))) << (8*k));
    end
    if (is_if) begin
      if_valid = 1'b1; if_addr = addr;
    end else begin
      ls_valid = 1'b1; ls_wr = wr; ls_addr = addr; ls_size = size; ls_wdata = wd;
    end
    for (int c = 1; c <= lat + 2 && !seen; c++) begin
      step();
      if (c <= n) begin
        checks++;
        if (mem_a !== addr + 32'(c - 1) || mem_wr !== wr) begin
          errors++;
          $display("FAIL txn_bus cyc=%0d mem_a=%h mem_wr=%b expected %h %b",
                   c, mem_a, mem_wr, addr + 32'(c - 1), wr);
        end
        if (wr) begin
          checks++;
          if (mem_dout !== wd[8*(c-1) +: 8]) begin
            errors++;
            $display("FAIL txn_wdata cyc=%0d got=%h expected=%h", c, mem_dout, wd[8*(c-1) +: 8]);
          end
        end
      end
      r = is_if ? if_ready : ls_ready;
      if (r === 1'b1) begin
        seen = 1'b1;
        if_valid = 1'b0;
        ls_valid = 1'b0;
        checks++;
        if (c != lat) begin
          errors++;
          $display("FAIL txn_latency got=%0d expected=%0d", c, lat);
        end
        if (!wr) begin
          checks++;
          if ((is_if ? if_data : ls_rdata) !== exp) begin
            errors++;
            $display("FAIL txn_rdata got=%h expected=%h", is_if ? if_data : ls_rdata, exp);
          end
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL txn_timeout addr=%h ready never seen within %0d cycles", addr, lat + 2);
      if_valid = 1'b0;
      ls_valid = 1'b0;
    end
    step();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    checks++;
    if (mem_wr !== 1'b0 || mem_a !== '0 || mem_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus wr=%b a=%h dout=%h expected 0 0 0", mem_wr, mem_a, mem_dout);
    end
    checks++;
    if (if_ready !== 1'b0 || ls_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready if=%b ls=%b expected 0 0", if_ready, ls_ready);
    end
    checks++;
    if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data if=%h ls=%h expected 0 0", if_data, ls_rdata);
    end
  endtask

  task automatic test_fetch();
    preload(32'h100, 32'h00100513, 4);
    do_txn(1'b1, 1'b0, 32'h100, 2'd2, 32'h0);
    checks++;
    if (if_data !== 32'h00100513) begin
      errors++;
      $display("FAIL fetch_word got=%h expected=00100513", if_data);
    end
  endtask

  task automatic test_load_half();
    preload(32'h1004, 32'h0000BEEF, 2);
    do_txn(1'b0, 1'b0, 32'h1004, 2'd1, 32'h0);
    checks++;
    if (ls_rdata !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL load_half got=%h expected=0000beef", ls_rdata);
    end
  endtask

  task automatic test_io_store();
    io_buffer_full = 1'b1;
    ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h30000; ls_size = 2'd0; ls_wdata = 32'h41;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 4) begin
        io_buffer_full = 1'b0;
        #1;
      end
      checks++;
      if (mem_wr !== 1'(c == 4)) begin
        errors++;
        $display("FAIL io_wr cyc=%0d got=%b expected=%b", c, mem_wr, c == 4);
      end
      if (c == 4) begin
        checks++;
        if (mem_a !== 32'h30000 || mem_dout !== 8'h41) begin
          errors++;
          $display("FAIL io_bus got a=%h d=%h expected 30000 41", mem_a, mem_dout);
        end
      end
      checks++;
      if (ls_ready !== 1'(c == 5)) begin
        errors++;
        $display("FAIL io_ready cyc=%0d got=%b expected=%b", c, ls_ready, c == 5);
      end
      if (ls_ready === 1'b1) ls_valid = 1'b0;
    end
    mdl[32'h30000] = 8'h41;
    checks++;
    if (ram_rd(32'h30000) !== 8'h41) begin
      errors++;
      $display("FAIL io_ram got=%h expected=41", ram_rd(32'h30000));
    end
  endtask

  // Both ports held valid; the model alternates grants starting with load/store.
  task automatic test_tie();
    bit last_if, exp_ls, got_ls, seen;
    logic [31:0] ea;
    logic [7:0] eb;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    last_if = 1'b1;
    ea = '0;
    for (int k = 0; k < 4; k++) ea = ea | (32'(mdl_rd(32'h800 + 32'(k))) << (8*k));
    eb = mdl_rd(32'h900);
    if_valid = 1'b1; if_addr = 32'h800;
    ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h900; ls_size = 2'd0;
    step();
    checks++;
    if (mem_a !== 32'h900) begin
      errors++;
      $display("FAIL tie_first_addr got=%h expected=00000900", mem_a);
    end
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      exp_ls = last_if;
      for (int w = 0; w < 16 && !seen; w++) begin
        if (if_ready === 1'b1 || ls_ready === 1'b1) begin
          seen = 1'b1;
          got_ls = (ls_ready === 1'b1);
          checks++;
          if (got_ls !== exp_ls) begin
            errors++;
            $display("FAIL tie_order grant=%0d got_ls=%b expected_ls=%b", g, got_ls, exp_ls);
          end
          checks++;
          if (got_ls ? (ls_rdata !== {24'h0, eb}) : (if_data !== ea)) begin
            errors++;
            $display("FAIL tie_data grant=%0d if=%h ls=%h expected if=%h ls=%h",
                     g, if_data, ls_rdata, ea, {24'h0, eb});
          end
        end
        step();
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL tie_timeout grant=%0d no ready within 16 cycles", g);
      end
      last_if = !exp_ls;
    end
    if_valid = 1'b0;
    ls_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_flush();
    ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2000; ls_size = 2'd2;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 3) begin
        if_flush = 1'b1;
        ls_valid = 1'b0;
      end
      if (c == 4) begin
        if_flush = 1'b0;
        checks++;
        if (mem_a !== 32'h0) begin
          errors++;
          $display("FAIL flush_idle got mem_a=%h expected=0", mem_a);
        end
      end
      checks++;
      if (ls_ready !== 1'b0 || mem_wr !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet cyc=%0d ls_ready=%b mem_wr=%b expected 0 0", c, ls_ready, mem_wr);
      end
    end
    // A request arriving with a flush in IDLE must be ignored.
    if_valid = 1'b1; if_addr = 32'h2400; if_flush = 1'b1;
    step();
    if_valid = 1'b0; if_flush = 1'b0;
    checks++;
    if (mem_a !== 32'h0) begin
      errors++;
      $display("FAIL flush_nogrant got mem_a=%h expected=0", mem_a);
    end
    step();
    do_txn(1'b1, 1'b0, 32'h2400, 2'd2, 32'h0);
  endtask

  task automatic test_pause();
    logic [31:0] exp;
    bit seen;
    exp = '0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) exp = exp | (32'(mdl_rd(32'h400 + 32'(k))) << (8*k));
    if_valid = 1'b1; if_addr = 32'h400;
    for (int c = 1; c <= 14 && !seen; c++) begin
      step();
      if (c == 2) rdy_in = 1'b0;
      if (c == 5) rdy_in = 1'b1;
      if (c >= 6 && c <= 9) begin
        checks++;
        if (mem_a !== 32'h400 + 32'(c - 6)) begin
          errors++;
          $display("FAIL pause_addr cyc=%0d got=%h expected=%h", c, mem_a, 32'h400 + 32'(c - 6));
        end
      end
      if (if_ready === 1'b1) begin
        seen = 1'b1;
        if_valid = 1'b0;
        checks++;
        if (c != 11) begin
          errors++;
          $display("FAIL pause_latency got=%0d expected=11", c);
        end
        checks++;
        if (if_data !== exp) begin
          errors++;
          $display("FAIL pause_data got=%h expected=%h", if_data, exp);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL pause_timeout no if_ready within 14 cycles");
      if_valid = 1'b0;
    end
    rdy_in = 1'b1;
    step();
  endtask

  task automatic test_reset_store();
    logic [7:0] d2, d3;
    d2 = ram_rd(32'h5002);
    d3 = ram_rd(32'h5003);
    ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h5000; ls_size = 2'd2; ls_wdata = 32'hA1B2C3D4;
    step();
    step();
    checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h5001) begin
      errors++;
      $display("FAIL rststore_byte1 wr=%b a=%h expected 1 00005001", mem_wr, mem_a);
    end
    rst_in = 1'b1;
    ls_valid = 1'b0;
    step();
    rst_in = 1'b0;
    mdl[32'h5000] = 8'hD4;
    mdl[32'h5001] = 8'hC3;
    checks++;
    if (mem_wr !== 1'b0 || mem_a !== '0 || mem_dout !== 8'h0 || if_ready !== 1'b0 ||
        ls_ready !== 1'b0 || if_data !== 32'h0 || ls_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rststore_outputs wr=%b a=%h d=%h ifr=%b lsr=%b ifd=%h lsd=%h expected all 0",
               mem_wr, mem_a, mem_dout, if_ready, ls_ready, if_data, ls_rdata);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (mem_wr !== 1'b0) begin
        errors++;
        $display("FAIL rststore_wr cyc=%0d got=%b expected=0", c, mem_wr);
      end
    end
    checks++;
    if (ram_rd(32'h5002) !== d2 || ram_rd(32'h5003) !== d3) begin
      errors++;
      $display("FAIL rststore_ram got=%h %h expected=%h %h", ram_rd(32'h5002), ram_rd(32'h5003), d2, d3);
    end
  endtask

  task automatic test_random();
    bit is_if, wr;
    logic [31:0] addr, wd;
    logic [1:0] size;
    for (int i = 0; i < 40; i++) begin
      is_if = ($urandom_range(0, 2) == 0);
      wr    = !is_if && ($urandom_range(0, 1) == 1);
      addr  = $urandom;
      if ($urandom_range(0, 4) == 0) addr = 32'hFFFF_FFFD;
      size  = 2'($urandom_range(0, 3));
      wd    = $urandom;
      do_txn(is_if, wr, addr, size, wd);
      if (wr) do_txn(1'b0, 1'b0, addr, 2'd2, 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; if_flush = 1'b0;
    if_valid = 1'b0; if_addr = '0;
    ls_valid = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_size = 2'd0; ls_wdata = '0;
    test_reset();
    test_fetch();
    test_load_half();
    test_io_store();
    test_tie();
    test_flush();
    test_pause();
    test_reset_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
